alu_issue_stage: RTL and testbench

- Decode/issue stage that drives the RV64I execute ALU. It takes a fetched instruction plus register-file reads and produces the ALU operand/control bundle: a, b, type_i, ifunsigned, alu_op.
- The bundle is held in a registered ID/EX pipeline slot with valid/ready handshake, stall and flush.
- It is the producer end of the ALU interface. Its outputs connect directly to the ALU inputs.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_issue_decode.sv | 178 +++++++++++++++++
 rtl/alu_issue_stage.sv | 131 +++++++++++++
 tb/tb_alu_issue_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU issue path.
//   - RV64I major opcodes the issue stage understands
//   - 4-bit ALU operation codes driven on alu_op
//   - issue_bundle_t: control fields held in the ID/EX slot
package alu_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    // Operands (a, b, pc) are XLEN-parametric and live beside this struct.
    typedef struct packed {
        logic [6:0] op_type;
        logic       ifunsigned;
        alu_op_e    alu_op;
        logic [4:0] rd;
        logic       wen;
        logic       illegal;
    } issue_bundle_t;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational RV64I decode for the ALU.
//   inst       : instruction word
//   pc         : instruction PC (AUIPC operand a)
//   rs1, rs2   : register operands (already forwarded by the caller)
//   a, b       : ALU operands
//   ctrl       : control bundle (type, ifunsigned, alu_op, rd, wen, illegal)
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output issue_bundle_t   ctrl
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt6;
    logic [XLEN-1:0] shamt5;
    logic            legal;
    logic            wen;
    logic            uns;
    alu_op_e         op;
    logic            unused_rs_field;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'h000};
    assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};
    assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};
    // rs1 field is only consulted by the forwarding compare in the top.
    assign unused_rs_field = ^inst[19:15];

    always_comb begin
        legal = 1'b1;
        wen   = 1'b0;
        uns   = 1'b0;
        op    = ALU_ADD;
        a     = '0;
        b     = '0;
        case (opcode)
            OPC_OP_IMM: begin
                a   = rs1;
                b   = imm_i;
                wen = 1'b1;
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        op    = ALU_SLL;
                        b     = shamt6;
                        legal = (inst[31:26] == 6'b000000);
                    end
                    default: begin // 3'b101: srli / srai
                        op    = inst[30] ? ALU_SRA : ALU_SRL;
                        b     = shamt6;
                        legal = ({inst[31], inst[29:26]} == 5'b00000);
                    end
                endcase
            end
            OPC_OP: begin
                a     = rs1;
                b     = rs2;
                wen   = 1'b1;
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                case (funct3)
                    3'b000:  op = inst[30] ? ALU_SUB : ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = inst[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            OPC_OP_IMM_32: begin
                a   = rs1;
                wen = 1'b1;
                case (funct3)
                    3'b000: begin
                        op = ALU_ADD;
                        b  = imm_i;
                    end
                    3'b001: begin
                        op    = ALU_SLL;
                        b     = shamt5;
                        legal = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        op    = inst[30] ? ALU_SRA : ALU_SRL;
                        b     = shamt5;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_32: begin
                a   = rs1;
                b   = rs2;
                wen = 1'b1;
                case (funct3)
                    3'b000: begin
                        op    = inst[30] ? ALU_SUB : ALU_ADD;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    3'b001: begin
                        op    = ALU_SLL;
                        legal = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        op    = inst[30] ? ALU_SRA : ALU_SRL;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                b   = imm_u;
                wen = 1'b1;
            end
            OPC_AUIPC: begin
                a   = pc;
                b   = imm_u;
                wen = 1'b1;
            end
            OPC_BRANCH: begin
                a = rs1;
                b = rs2;
                case (funct3)
                    3'b000, 3'b001: op = ALU_SUB;
                    3'b100, 3'b101: op = ALU_SLT;
                    3'b110, 3'b111: begin
                        op  = ALU_SLTU;
                        uns = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        // Illegal encodings still issue, but with a neutral, non-writing bundle.
        if (!legal) begin
            a   = '0;
            b   = '0;
            op  = ALU_ADD;
            wen = 1'b0;
            uns = 1'b0;
        end
        if (inst[11:7] == 5'd0) begin
            wen = 1'b0;
        end

        ctrl.op_type    = opcode;
        ctrl.ifunsigned = uns;
        ctrl.alu_op     = op;
        ctrl.rd         = inst[11:7];
        ctrl.wen        = wen;
        ctrl.illegal    = !legal;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue slot feeding the RV64I execute ALU.
//   Upstream : in_valid/in_ready, in_inst, in_pc, rs1_data, rs2_data
//   Control  : stall_i (hold slot), flush_i (kill slot, highest priority)
//   Downstream: out_valid/out_ready plus the registered ALU bundle
//              out_a, out_b, out_type, out_ifunsigned, out_alu_op,
//              out_rd, out_wen, out_pc, out_illegal
// Optional: define ALU_ISSUE_FORWARD_EN to add fwd_valid/fwd_rd/fwd_data,
// which override rs1_data/rs2_data when fwd_rd matches a nonzero source field.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_FORWARD_EN
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
`endif
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [6:0]      out_type,
    output logic            out_ifunsigned,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    logic [XLEN-1:0] rs1_eff;
    logic [XLEN-1:0] rs2_eff;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    issue_bundle_t   dec_ctrl;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] pc_q, pc_d;
    issue_bundle_t   ctrl_q, ctrl_d;

    always_comb begin
        rs1_eff = rs1_data;
        rs2_eff = rs2_data;
`ifdef ALU_ISSUE_FORWARD_EN
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_inst[19:15]) begin
            rs1_eff = fwd_data;
        end
        if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_inst[24:20]) begin
            rs2_eff = fwd_data;
        end
`endif
    end

    alu_issue_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst (in_inst),
        .pc   (in_pc),
        .rs1  (rs1_eff),
        .rs2  (rs2_eff),
        .a    (dec_a),
        .b    (dec_b),
        .ctrl (dec_ctrl)
    );

    assign in_ready = !stall_i && (!valid_q || out_ready);

    // Priority: flush > stall > load > drain. Flush leaves data fields as-is.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (in_valid && in_ready) begin
            valid_d = 1'b1;
            a_d     = dec_a;
            b_d     = dec_b;
            pc_d    = in_pc;
            ctrl_d  = dec_ctrl;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            pc_q    <= RESET_PC;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_a          = a_q;
    assign out_b          = b_q;
    assign out_pc         = pc_q;
    assign out_type       = ctrl_q.op_type;
    assign out_ifunsigned = ctrl_q.ifunsigned;
    assign out_alu_op     = ctrl_q.alu_op;
    assign out_rd         = ctrl_q.rd;
    assign out_wen        = ctrl_q.wen;
    assign out_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboarded bench for alu_issue_stage: a mnemonic-level reference decoder
// produces the expected bundle at issue time; a negedge monitor pops and
// compares whenever the slot hands an instruction to execute.
module tb_alu_issue_stage;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        stall_i;
    logic        flush_i;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [6:0]  out_type;
    logic        out_ifunsigned;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [63:0] out_pc;
    logic        out_illegal;
`ifdef ALU_ISSUE_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
`endif

    alu_issue_stage #(
        .XLEN     (64),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
`ifdef ALU_ISSUE_FORWARD_EN
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
`endif
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_type       (out_type),
        .out_ifunsigned (out_ifunsigned),
        .out_alu_op     (out_alu_op),
        .out_rd         (out_rd),
        .out_wen        (out_wen),
        .out_pc         (out_pc),
        .out_illegal    (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] pc;
        logic [6:0]  typ;
        logic        uns;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t p_exp;
    logic p_load;
    logic p_flush;
    logic mon_en;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] op_of(input string m);
        case (m)
            "beq", "bne", "sub", "subw":                    return 4'd1;
            "and", "andi":                                  return 4'd2;
            "or", "ori":                                    return 4'd3;
            "xor", "xori":                                  return 4'd4;
            "slt", "slti", "blt", "bge":                    return 4'd5;
            "sltu", "sltiu", "bltu", "bgeu":                return 4'd6;
            "sll", "slli", "sllw", "slliw":                 return 4'd7;
            "srl", "srli", "srlw", "srliw":                 return 4'd8;
            "sra", "srai", "sraw", "sraiw":                 return 4'd9;
            default:                                        return 4'd0;
        endcase
    endfunction

    // kind: 0 reg-reg, 1 reg-imm, 2 shamt6, 3 shamt5, 4 lui, 5 auipc, 6 branch
    function automatic exp_t ref_model(input logic [31:0] inst, input logic [63:0] pc,
                                       input logic [63:0] r1, input logic [63:0] r2);
        exp_t        e;
        string       m;
        int          kind;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm_i;
        logic [63:0] imm_u;
        string r_names[8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
        string i_names[8] = '{"addi", "", "slti", "sltiu", "xori", "", "ori", "andi"};
        string b_names[8] = '{"beq", "bne", "", "", "blt", "bge", "bltu", "bgeu"};
        opc   = inst[6:0];
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = 64'($signed(inst[31:20]));
        imm_u = 64'($signed({inst[31:12], 12'h000}));
        m     = "";
        kind  = 0;
        case (opc)
            7'h13: begin
                kind = 1;
                m    = i_names[f3];
                if (f3 == 3'd1 && inst[31:26] == 6'd0) begin
                    m = "slli"; kind = 2;
                end
                if (f3 == 3'd5) begin
                    kind = 2;
                    if (inst[31:26] == 6'b000000)      m = "srli";
                    else if (inst[31:26] == 6'b010000) m = "srai";
                end
            end
            7'h33: begin
                if (f7 == 7'h00)                   m = r_names[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
                else if (f7 == 7'h20 && f3 == 3'd5) m = "sra";
            end
            7'h1b: begin
                if (f3 == 3'd0) begin
                    m = "addiw"; kind = 1;
                end else if (f3 == 3'd1 && f7 == 7'h00) begin
                    m = "slliw"; kind = 3;
                end else if (f3 == 3'd5 && f7 == 7'h00) begin
                    m = "srliw"; kind = 3;
                end else if (f3 == 3'd5 && f7 == 7'h20) begin
                    m = "sraiw"; kind = 3;
                end
            end
            7'h3b: begin
                if (f7 == 7'h00 && f3 == 3'd0)      m = "addw";
                else if (f7 == 7'h00 && f3 == 3'd1) m = "sllw";
                else if (f7 == 7'h00 && f3 == 3'd5) m = "srlw";
                else if (f7 == 7'h20 && f3 == 3'd0) m = "subw";
                else if (f7 == 7'h20 && f3 == 3'd5) m = "sraw";
            end
            7'h37: begin m = "lui";   kind = 4; end
            7'h17: begin m = "auipc"; kind = 5; end
            7'h63: begin m = b_names[f3]; kind = 6; end
            default: m = "";
        endcase
        e.a = '0; e.b = '0; e.uns = 1'b0; e.op = 4'd0; e.wen = 1'b0; e.ill = 1'b0;
        e.typ = opc;
        e.rd  = inst[11:7];
        e.pc  = pc;
        if (m == "") begin
            e.ill = 1'b1;
        end else begin
            e.op  = op_of(m);
            e.uns = (m == "bltu" || m == "bgeu");
            case (kind)
                1:       begin e.a = r1;  e.b = imm_i; end
                2:       begin e.a = r1;  e.b = 64'(inst[25:20]); end
                3:       begin e.a = r1;  e.b = 64'(inst[24:20]); end
                4:       begin e.a = '0;  e.b = imm_u; end
                5:       begin e.a = pc;  e.b = imm_u; end
                default: begin e.a = r1;  e.b = r2; end
            endcase
            e.wen = (kind != 6) && (inst[11:7] != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs[7] = '{7'h13, 7'h33, 7'h1b, 7'h3b, 7'h37, 7'h17, 7'h63};
        logic [31:0] w;
        logic [6:0]  opc;
        logic [6:0]  f7;
        int unsigned k;
        int unsigned s;
        w = $urandom();
        k = $urandom_range(0, 7);
        opc = (k < 7) ? opcs[k] : w[6:0];
        s = $urandom_range(0, 3);
        f7 = (s < 2) ? 7'h00 : (s == 2) ? 7'h20 : w[31:25];
        return {f7, w[24:20], 5'($urandom_range(0, 3)), w[14:12], w[11:7], opc};
    endfunction

`ifdef ALU_ISSUE_FORWARD_EN
    logic        tb_fv;
    logic [4:0]  tb_frd;
    logic [63:0] tb_fdata;
`endif

    // One cycle: retire the effect of the previous cycle's inputs into the
    // scoreboard, then drive new inputs and check the combinational ready.
    task automatic step(input logic [31:0] inst, input logic v, input logic st,
                        input logic fl, input logic ordy,
                        input logic [63:0] r1, input logic [63:0] r2);
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] pcv;
        logic        rdy_exp;
        @(posedge clk);
        #2;
        if (p_flush)     q.delete();
        else if (p_load) q.push_back(p_exp);
        pcv       = {$urandom(), $urandom()};
        in_inst   = inst;
        in_valid  = v;
        stall_i   = st;
        flush_i   = fl;
        out_ready = ordy;
        rs1_data  = r1;
        rs2_data  = r2;
        in_pc     = pcv;
        e1 = r1;
        e2 = r2;
`ifdef ALU_ISSUE_FORWARD_EN
        fwd_valid = tb_fv;
        fwd_rd    = tb_frd;
        fwd_data  = tb_fdata;
        if (tb_fv && tb_frd != 5'd0 && tb_frd == inst[19:15]) e1 = tb_fdata;
        if (tb_fv && tb_frd != 5'd0 && tb_frd == inst[24:20]) e2 = tb_fdata;
`endif
        rdy_exp = !st && (q.size() == 0 || ordy);
        #1;
        chk("in_ready", in_ready, rdy_exp);
        p_exp   = ref_model(inst, pcv, e1, e2);
        p_load  = v && rdy_exp && !fl;
        p_flush = fl;
    endtask

    // Monitor: occupancy every cycle, full bundle on each hand-off to execute.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            chk("sb_valid", out_valid, q.size() != 0);
            if (out_valid && out_ready && !stall_i && !flush_i && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_a",       out_a,          e.a);
                chk("sb_b",       out_b,          e.b);
                chk("sb_pc",      out_pc,         e.pc);
                chk("sb_type",    out_type,       e.typ);
                chk("sb_uns",     out_ifunsigned, e.uns);
                chk("sb_alu_op",  out_alu_op,     e.op);
                chk("sb_rd",      out_rd,         e.rd);
                chk("sb_wen",     out_wen,        e.wen);
                chk("sb_illegal", out_illegal,    e.ill);
            end
        end
    end

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SRAI  = 32'h43F1D113;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_BADW  = {7'b0000001, 5'd3, 5'd1, 3'b001, 5'd5, 7'b0011011};

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        rs1_data = '0; rs2_data = '0; stall_i = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
        p_load = 1'b0; p_flush = 1'b0; mon_en = 1'b0;
`ifdef ALU_ISSUE_FORWARD_EN
        tb_fv = 1'b0; tb_frd = '0; tb_fdata = '0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
        #12;
        chk("rst_valid",   out_valid,   1'b0);
        chk("rst_pc",      out_pc,      RPC);
        chk("rst_a",       out_a,       64'd0);
        chk("rst_b",       out_b,       64'd0);
        chk("rst_alu_op",  out_alu_op,  4'd0);
        chk("rst_wen",     out_wen,     1'b0);
        chk("rst_illegal", out_illegal, 1'b0);
        @(negedge clk); #2;
        rstn = 1'b1;
        mon_en = 1'b1;

        // addi, then back-pressure for three cycles
        step(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd7);
        for (int i = 0; i < 3; i++) begin
            step(I_SRAI, 1'b1, 1'b0, 1'b0, 1'b0, 64'd11, 64'd0);
            chk("addi_valid", out_valid, 1'b1);
            chk("addi_a",     out_a,     64'd0);
            chk("addi_b",     out_b,     64'd5);
            chk("addi_op",    out_alu_op, 4'd0);
            chk("addi_type",  out_type,  7'h13);
            chk("addi_rd",    out_rd,    5'd1);
            chk("addi_wen",   out_wen,   1'b1);
        end
        step(I_SRAI, 1'b1, 1'b0, 1'b0, 1'b1, 64'd11, 64'd0);
        step(I_BLTU, 1'b1, 1'b0, 1'b0, 1'b0, 64'd1, 64'd2);
        chk("srai_b",  out_b,      64'd63);
        chk("srai_op", out_alu_op, 4'd9);
        step(I_BLTU, 1'b1, 1'b0, 1'b0, 1'b1, 64'd1, 64'd2);
        // stall with a new instruction offered: slot must hold bltu
        step(I_ADDI, 1'b1, 1'b1, 1'b0, 1'b1, 64'd0, 64'd0);
        chk("bltu_op",  out_alu_op,     4'd6);
        chk("bltu_uns", out_ifunsigned, 1'b1);
        chk("bltu_wen", out_wen,        1'b0);
        step(I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("stall_hold_op", out_alu_op, 4'd6);
        chk("stall_hold_rd", out_rd,     5'd8);
        // flush beats stall and load
        step(I_ADDI, 1'b1, 1'b1, 1'b1, 1'b1, 64'd0, 64'd0);
        step(I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("flush_valid", out_valid, 1'b0);
        // illegal OP-IMM-32 shift with inst[25]=1
        step(I_BADW, 1'b1, 1'b0, 1'b0, 1'b1, 64'd9, 64'd9);
        step(I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("ill_valid",   out_valid,   1'b1);
        chk("ill_illegal", out_illegal, 1'b1);
        chk("ill_wen",     out_wen,     1'b0);
        chk("ill_a",       out_a,       64'd0);
        // asynchronous reset with a live slot
        rstn = 1'b0;
        in_valid = 1'b0; flush_i = 1'b0; stall_i = 1'b0; out_ready = 1'b0;
        p_load = 1'b0; p_flush = 1'b0;
        q.delete();
        #1;
        chk("arst_valid",   out_valid,   1'b0);
        chk("arst_pc",      out_pc,      RPC);
        chk("arst_illegal", out_illegal, 1'b0);
        @(negedge clk); #2;
        rstn = 1'b1;

`ifdef ALU_ISSUE_FORWARD_EN
        tb_fv = 1'b1; tb_frd = 5'd1; tb_fdata = 64'hDEAD;
        step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 64'd4);
        step(I_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd4);
        chk("fwd_a", out_a, 64'hDEAD);
        tb_frd = 5'd0;
        step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 64'd4);
        step(I_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd4);
        chk("fwd_rd0_a", out_a, 64'd0);
`endif

        for (int n = 0; n < 600; n++) begin
`ifdef ALU_ISSUE_FORWARD_EN
            tb_fv    = 1'($urandom_range(0, 1));
            tb_frd   = 5'($urandom_range(0, 3));
            tb_fdata = {$urandom(), $urandom()};
`endif
            step(rand_inst(),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 {$urandom(), $urandom()},
                 {$urandom(), $urandom()});
        end
        for (int n = 0; n < 3; n++) begin
            step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
        end
        @(negedge clk);
        chk("drained", q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
